bram_stall_port_client: RTL

Requester-side controller for one port of the stall-capable dual-port BRAM, where the port clock enable is EN OR DEQ. It converts a valid/ready request stream of reads and writes into BRAM port strobes. It tracks in-flight reads through the BRAM read pipeline and returns read data on a valid/ready response stream. When the consumer back-pressures, it freezes the BRAM pipeline through its clock enable, so no data is lost and no response FIFO is needed. One instance sits in front of each BRAM port that needs back-pressure.

---
 rtl/bram_stall_port_client.sv | 74 +++++++
 1 files changed

// File: rtl/bram_stall_port_client.sv
// Requester-side front end for one port of a stall-capable BRAM (clock enable = EN | DEQ).
// Consumer back-pressure freezes the BRAM read pipeline, so no response storage is needed.
module bram_stall_port_client #(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter int PIPELINED  = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ_DATA,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   output logic                  BRAM_EN,
   output logic                  BRAM_WE,
   output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
   output logic [DATA_WIDTH-1:0] BRAM_DI,
   output logic                  BRAM_DEQ,
   input  logic [DATA_WIDTH-1:0] BRAM_DO,
   output logic [1:0]            INFLIGHT,
   output logic                  IDLE
);

   localparam int L = (PIPELINED != 0) ? 2 : 1;

   // v_q[i] marks a read occupying BRAM pipeline stage i; v_q[L-1] is on BRAM_DO.
   logic [1:0] v_q, v_d;
   logic       rsp_vld;
   logic       adv;
   logic       issue;
   logic       drain;
   logic       ce;
   logic [1:0] inflight;

   assign rsp_vld  = v_q[L-1];
   assign adv      = !rsp_vld | RSP_READY;
   assign inflight = {1'b0, v_q[0]} + {1'b0, v_q[1]};
   assign issue    = REQ_VALID & adv & !RST;
   // Drain pulses only advance the pipeline; they never coincide with an issue.
   assign drain    = adv & !issue & (inflight != 2'd0) & !RST;
   assign ce       = issue | drain;

   always_comb begin
      v_d = v_q;
      if (ce) begin
         v_d[0] = issue & !REQ_WE;
         v_d[1] = (L == 2) ? v_q[0] : 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         v_q <= 2'b00;
      end else begin
         v_q <= v_d;
      end
   end

   assign REQ_READY = adv & !RST;
   assign BRAM_EN   = issue;
   assign BRAM_WE   = REQ_WE;
   assign BRAM_ADDR = REQ_ADDR;
   assign BRAM_DI   = REQ_DATA;
   assign BRAM_DEQ  = drain;
   assign RSP_VALID = rsp_vld;
   assign RSP_DATA  = BRAM_DO;
   assign INFLIGHT  = inflight;
   assign IDLE      = (inflight == 2'd0) & !REQ_VALID;

endmodule
